// File: rtl/alu_operand_regfile_if.sv
// Handshake and data bundle for the ALU operand-fetch/writeback stage.
// "slave" is the stage's view; "master" is the view of the environment that
// drives instructions in and provides the ALU result and flags.
interface alu_operand_regfile_if #(
    parameter int unsigned NREGS = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned RW = $clog2(NREGS);

    // Instruction side
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [RW-1:0]    in_rd;
    logic [RW-1:0]    in_rs1;
    logic [RW-1:0]    in_rs2;
    logic [3:0]       in_imm;
    logic             in_use_imm;

    // ALU side
    logic             alu_valid;
    logic             alu_ready;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_r;
    logic [5:0]       alu_flags;

    // Status and debug
    logic [5:0]       flags;
    logic [RW-1:0]    dbg_sel;
    logic [WIDTH-1:0] dbg_data;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_use_imm,
        output in_ready,
        input  alu_ready, alu_r, alu_flags,
        output alu_valid, alu_a, alu_b, alu_op,
        output flags,
        input  dbg_sel,
        output dbg_data
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_use_imm,
        input  in_ready,
        output alu_ready, alu_r, alu_flags,
        input  alu_valid, alu_a, alu_b, alu_op,
        input  flags,
        output dbg_sel,
        input  dbg_data
    );
endinterface

// File: rtl/alu_operand_regfile.sv
// Operand-fetch/writeback stage in front of the 8-bit ALU.
// Holds a small register file (reg 0 reads as zero), registers operands and
// opcode for the ALU in a single-entry pipeline register, and writes the
// ALU result/flags back on commit.
// Optional feature macro: ALU_FWD_EN
//   defined   : a read of the register being committed this cycle is bypassed
//               from alu_r, so back-to-back dependent instructions never stall.
//   undefined : such a read stalls the instruction for one cycle so it reads
//               the updated register file.
module alu_operand_regfile #(
    parameter int unsigned NREGS = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    alu_operand_regfile_if.slave   bus
);
    localparam int unsigned RW = $clog2(NREGS);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             alu_valid_q, alu_valid_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [RW-1:0]    rd_q, rd_d;
    logic [5:0]       flags_q, flags_d;

    logic             commit;
    logic             accept;
    logic             in_ready;
    logic             hit_a;
    logic             hit_b;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] opnd_b;

    // Handshake: commit/accept decisions and dependency detection against the committing rd
    always_comb begin
        commit = alu_valid_q && bus.alu_ready;
        hit_a  = commit && (rd_q != '0) && (rd_q == bus.in_rs1);
        hit_b  = commit && (rd_q != '0) && !bus.in_use_imm && (rd_q == bus.in_rs2);
`ifdef ALU_FWD_EN
        in_ready = !alu_valid_q || bus.alu_ready;
`else
        in_ready = (!alu_valid_q || bus.alu_ready) && !(hit_a || hit_b);
`endif
        accept = bus.in_valid && in_ready;
    end

    // Operand selection: reg 0 is zero, B optionally the sign-extended immediate
    always_comb begin
        imm_sext = {{(WIDTH-4){bus.in_imm[3]}}, bus.in_imm};
        opnd_a   = (bus.in_rs1 == '0) ? '0 : regs_q[bus.in_rs1];
        opnd_b   = (bus.in_rs2 == '0) ? '0 : regs_q[bus.in_rs2];
`ifdef ALU_FWD_EN
        if (hit_a) begin
            opnd_a = bus.alu_r;
        end
        if (hit_b) begin
            opnd_b = bus.alu_r;
        end
`endif
        if (bus.in_use_imm) begin
            opnd_b = imm_sext;
        end
    end

    // Next state: writeback on commit, then load of a new instruction on accept
    // (accept is applied last so a same-cycle accept keeps alu_valid set)
    always_comb begin
        regs_d      = regs_q;
        alu_valid_d = alu_valid_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        flags_d     = flags_q;
        if (commit) begin
            if (rd_q != '0) begin
                regs_d[rd_q] = bus.alu_r;
            end
            flags_d     = bus.alu_flags;
            alu_valid_d = 1'b0;
        end
        if (accept) begin
            alu_valid_d = 1'b1;
            alu_a_d     = opnd_a;
            alu_b_d     = opnd_b;
            alu_op_d    = bus.in_op;
            rd_d        = bus.in_rd;
        end
    end

    // State registers with synchronous active-high reset discarding pipeline content
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            alu_valid_q <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            flags_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            alu_valid_q <= alu_valid_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            flags_q     <= flags_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.alu_valid = alu_valid_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.flags     = flags_q;
    assign bus.dbg_data  = (bus.dbg_sel == '0) ? '0 : regs_q[bus.dbg_sel];
endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed bench for alu_operand_regfile with a reference ALU stand-in,
// a reference register file, and an operand scoreboard checked at commit.
module tb_alu_operand_regfile;
    localparam int unsigned NREGS = 4;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_operand_regfile_if #(.NREGS(NREGS), .WIDTH(WIDTH)) bus ();

    alu_operand_regfile #(.NREGS(NREGS), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference ALU: returns {r[7:0], z, n, vn, vp, br, c}
    function automatic logic [13:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [1:0] op);
        logic [15:0] p;
        logic [8:0]  s;
        logic [7:0]  r;
        logic        vn, vp, br, c;
        vn = 1'b0; vp = 1'b0; br = 1'b0; c = 1'b0;
        p = '0; s = '0;
        case (op)
            2'b00: r = a & b;
            2'b01: begin
                r  = a - b;
                br = (a < b);
                vp = !a[7] && b[7] && r[7];
                vn = a[7] && !b[7] && !r[7];
            end
            2'b10: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[7:0];
                c  = s[8];
                vp = !a[7] && !b[7] && r[7];
                vn = a[7] && b[7] && !r[7];
            end
            default: begin
                p = {8'h00, a} * {8'h00, b};
                r = p[7:0];
                c = |p[15:8];
            end
        endcase
        return {r, (r == 8'h00), r[7], vn, vp, br, c};
    endfunction

    assign {bus.alu_r, bus.alu_flags} = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [5:0] fl;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] mregs [NREGS];
    int         errors = 0;
    int         checks = 0;
    int         commits = 0;
    bit         pend = 1'b0;
    logic [5:0] pend_fl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Commit monitor: pops the scoreboard when the stage hands a result to the ALU
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (pend) begin
            check("flags_after_commit", 32'(bus.flags), 32'(pend_fl));
            pend = 1'b0;
        end
        if (reset !== 1'b1 && bus.alu_valid === 1'b1 && bus.alu_ready === 1'b1) begin
            check("sb_nonempty", 32'(sbq.size() > 0), 32'h1);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_alu_a", 32'(bus.alu_a), 32'(e.a));
                check("sb_alu_b", 32'(bus.alu_b), 32'(e.b));
                check("sb_alu_op", 32'(bus.alu_op), 32'(e.op));
                pend_fl = e.fl;
                pend    = 1'b1;
            end
            commits++;
        end
    end

    // Offers one instruction until accepted (bounded); on accept, models it and pushes expectations
    task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [3:0] imm, input logic use_imm,
                         output int stalls);
        logic [7:0]  a, b;
        logic [13:0] m;
        exp_t        e;
        bit          done;
        stalls = 0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.in_op      = op;
            bus.in_rd      = rd;
            bus.in_rs1     = rs1;
            bus.in_rs2     = rs2;
            bus.in_imm     = imm;
            bus.in_use_imm = use_imm;
            #1;
            if (bus.in_ready === 1'b1) done = 1'b1;
            else stalls++;
            @(posedge clk);
        end
        check("accept_within_bound", 32'(done), 32'h1);
        if (done) begin
            a = (rs1 == 2'd0) ? 8'h00 : mregs[rs1];
            b = use_imm ? {{4{imm[3]}}, imm} : ((rs2 == 2'd0) ? 8'h00 : mregs[rs2]);
            m = alu_model(a, b, op);
            if (rd != 2'd0) mregs[rd] = m[13:6];
            e.a = a; e.b = b; e.op = op; e.fl = m[5:0];
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        bus.dbg_sel = sel;
        #1;
        check(tag, 32'(bus.dbg_data), 32'(exp));
    endtask

    initial begin
        int st;
        int tot;
        int c0;
        int exp_st;
`ifdef ALU_FWD_EN
        exp_st = 0;
`else
        exp_st = 1;
`endif
        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_op      = 2'b00;
        bus.in_rd      = 2'd0;
        bus.in_rs1     = 2'd0;
        bus.in_rs2     = 2'd0;
        bus.in_imm     = 4'h0;
        bus.in_use_imm = 1'b0;
        bus.alu_ready  = 1'b1;
        bus.dbg_sel    = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_alu_valid", 32'(bus.alu_valid), 32'h0);
        check("rst_alu_a", 32'(bus.alu_a), 32'h0);
        check("rst_alu_b", 32'(bus.alu_b), 32'h0);
        check("rst_alu_op", 32'(bus.alu_op), 32'h0);
        check("rst_flags", 32'(bus.flags), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Immediate operand: ADD r1 = r0 + sext(C)
        issue(2'b10, 2'd1, 2'd0, 2'd0, 4'hC, 1'b1, st);
        #1;
        check("imm_alu_a", 32'(bus.alu_a), 32'h00);
        check("imm_alu_b", 32'(bus.alu_b), 32'hFC);
        check("imm_alu_op", 32'(bus.alu_op), 32'h2);
        idle(2);
        check_reg("imm_reg1", 2'd1, 8'hFC);
        check("imm_flags", 32'(bus.flags), 32'h10);

        // Hazard: r1=05, then r2=r1+r1, then r3=r2-r1 back-to-back
        issue(2'b10, 2'd1, 2'd0, 2'd0, 4'h5, 1'b1, st);
        idle(2);
        check_reg("haz_reg1", 2'd1, 8'h05);
        issue(2'b10, 2'd2, 2'd1, 2'd1, 4'h0, 1'b0, st);
        issue(2'b01, 2'd3, 2'd2, 2'd1, 4'h0, 1'b0, st);
        check("haz_stalls", 32'(st), 32'(exp_st));
        #1;
        check("haz_alu_a", 32'(bus.alu_a), 32'h0A);
        check("haz_alu_b", 32'(bus.alu_b), 32'h05);
        check("haz_alu_op", 32'(bus.alu_op), 32'h1);
        idle(2);
        check_reg("haz_reg2", 2'd2, 8'h0A);
        check_reg("haz_reg3", 2'd3, 8'h05);

        // Backpressure: held instruction ADD r1 = r2 + 1 with a second one waiting
        bus.alu_ready = 1'b0;
        issue(2'b10, 2'd1, 2'd2, 2'd0, 4'h1, 1'b1, st);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_op      = 2'b01;
        bus.in_rd      = 2'd2;
        bus.in_rs1     = 2'd3;
        bus.in_rs2     = 2'd0;
        bus.in_imm     = 4'h2;
        bus.in_use_imm = 1'b1;
        bus.dbg_sel    = 2'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 32'h0);
            check("bp_alu_valid", 32'(bus.alu_valid), 32'h1);
            check("bp_alu_a", 32'(bus.alu_a), 32'h0A);
            check("bp_alu_b", 32'(bus.alu_b), 32'h01);
            check("bp_alu_op", 32'(bus.alu_op), 32'h2);
            check("bp_reg1_unwritten", 32'(bus.dbg_data), 32'h05);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.alu_ready = 1'b1;
        issue(2'b01, 2'd2, 2'd3, 2'd0, 4'h2, 1'b1, st);
        idle(2);
        check_reg("bp_reg1", 2'd1, 8'h0B);
        check_reg("bp_reg2", 2'd2, 8'h03);

        // r0 destination: MUL r0 = 0C * 5 = 3C, flags still updated
        issue(2'b10, 2'd1, 2'd0, 2'd0, 4'h6, 1'b1, st);
        idle(2);
        issue(2'b10, 2'd1, 2'd1, 2'd1, 4'h0, 1'b0, st);
        idle(2);
        issue(2'b01, 2'd2, 2'd0, 2'd0, 4'h1, 1'b1, st);
        idle(2);
        check_reg("r0_pre_reg2", 2'd2, 8'hFF);
        check("r0_pre_flags", 32'(bus.flags), 32'h12);
        issue(2'b11, 2'd0, 2'd1, 2'd0, 4'h5, 1'b1, st);
        #1;
        check("r0_alu_a", 32'(bus.alu_a), 32'h0C);
        check("r0_alu_b", 32'(bus.alu_b), 32'h05);
        check("r0_alu_r", 32'(bus.alu_r), 32'h3C);
        idle(2);
        check_reg("r0_reg0", 2'd0, 8'h00);
        check("r0_flags", 32'(bus.flags), 32'h00);
        check_reg("r0_reg1", 2'd1, 8'h0C);

        // Throughput: 8 independent instructions, one commit per cycle
        c0  = commits;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            issue(2'b10, 2'(i % 3 + 1), 2'd0, 2'd0, 4'(i), 1'b1, st);
            tot += st;
        end
        idle(1);
        #3;
        check("tp_stalls", 32'(tot), 32'h0);
        check("tp_commits", 32'(commits - c0), 32'h8);
        idle(2);
        for (int i = 1; i < NREGS; i++) check_reg("tp_reg", 2'(i), mregs[i]);

        // Reset mid-stall discards the held instruction and clears state
        issue(2'b01, 2'd1, 2'd0, 2'd0, 4'h1, 1'b1, st);
        idle(2);
        check("rs_pre_flags", 32'(bus.flags), 32'h12);
        bus.alu_ready = 1'b0;
        issue(2'b10, 2'd2, 2'd1, 2'd0, 4'h1, 1'b1, st);
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.alu_ready = 1'b1;
        sbq.delete();
        for (int i = 0; i < NREGS; i++) mregs[i] = 8'h00;
        #1;
        check("rs_alu_valid", 32'(bus.alu_valid), 32'h0);
        check("rs_alu_a", 32'(bus.alu_a), 32'h0);
        check("rs_flags", 32'(bus.flags), 32'h0);
        for (int i = 0; i < NREGS; i++) check_reg("rs_dbg", 2'(i), 8'h00);

        idle(2);
        check("sb_drained", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
